// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller: opcodes, ALU op codes, state encodings.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package multicycle_controller_pkg;

  // Instruction opcodes (6-bit MIPS-style encodings)
  localparam logic [5:0] OP_R_TYPE = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  // ALU operation codes. NOP is zero so an all-zero control word is idle.
  localparam logic [2:0] ALU_NOP    = 3'd0;
  localparam logic [2:0] ALU_ADD    = 3'd1;
  localparam logic [2:0] ALU_SUB    = 3'd2;
  localparam logic [2:0] ALU_AND    = 3'd3;
  localparam logic [2:0] ALU_OR     = 3'd4;
  localparam logic [2:0] ALU_R_TYPE = 3'd5;

  // Controller state encodings, visible on the state output
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } ctrl_state_t;

endpackage

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle CPU datapath, with retired-instruction counter.
// Latency: BEQ/J 3, R/I-type/SW 4, LW 5 cycles; +1 per memory wait cycle.
// Backpressure: FETCH, MEM_RD and MEM_WR hold while mem_ready=0.
// Ports: clk, reset_n (sync, active-low); opcode, zero, mem_ready in;
//   datapath control strobes/selects, state, instr_count, illegal_op out.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int LEN_OP_CODE = 6,
  parameter int LEN_ALU_OP  = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [LEN_OP_CODE-1:0] opcode,
  input  logic                   zero,
  input  logic                   mem_ready,
  output logic                   pc_en,
  output logic                   i_or_d,
  output logic                   ir_write,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   alu_src_a,
  output logic                   reg_dst,
  output logic                   reg_write,
  output logic                   mem_to_reg,
  output logic                   instr_done,
  output logic                   illegal_op,
  output logic [1:0]             pc_src,
  output logic [1:0]             alu_src_b,
  output logic [LEN_ALU_OP-1:0]  alu_op,
  output logic [3:0]             state,
  output logic [31:0]            instr_count
);

  ctrl_state_t state_q, state_d;

  logic is_r, is_j, is_beq, is_addi, is_andi, is_ori, is_lw, is_sw;

  assign is_r    = (opcode == LEN_OP_CODE'(OP_R_TYPE));
  assign is_j    = (opcode == LEN_OP_CODE'(OP_J));
  assign is_beq  = (opcode == LEN_OP_CODE'(OP_BEQ));
  assign is_addi = (opcode == LEN_OP_CODE'(OP_ADDI));
  assign is_andi = (opcode == LEN_OP_CODE'(OP_ANDI));
  assign is_ori  = (opcode == LEN_OP_CODE'(OP_ORI));
  assign is_lw   = (opcode == LEN_OP_CODE'(OP_LW));
  assign is_sw   = (opcode == LEN_OP_CODE'(OP_SW));

  assign state = state_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_FETCH;
      instr_count <= 32'd0;
    end else begin
      state_q <= state_d;
      if (instr_done) instr_count <= instr_count + 32'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src_a  = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    pc_src     = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = LEN_ALU_OP'(ALU_NOP);

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = LEN_ALU_OP'(ALU_ADD);
        // IR load and PC+4 only commit in the cycle the fetch completes
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch target precomputed here while the opcode is decoded
        alu_src_b = 2'b11;
        alu_op    = LEN_ALU_OP'(ALU_ADD);
        if (is_lw || is_sw)                  state_d = S_MEM_ADDR;
        else if (is_r)                       state_d = S_EXEC_R;
        else if (is_addi || is_ori || is_andi) state_d = S_EXEC_I;
        else if (is_beq)                     state_d = S_BRANCH;
        else if (is_j)                       state_d = S_JUMP;
        else begin
          illegal_op = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = LEN_ALU_OP'(ALU_ADD);
        state_d   = is_lw ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = LEN_ALU_OP'(ALU_R_TYPE);
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (is_ori)       alu_op = LEN_ALU_OP'(ALU_OR);
        else if (is_andi) alu_op = LEN_ALU_OP'(ALU_AND);
        else              alu_op = LEN_ALU_OP'(ALU_ADD);
        state_d = S_I_WB;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = LEN_ALU_OP'(ALU_SUB);
        pc_src     = 2'b01;
        pc_en      = zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_en      = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset is synchronous, but the datapath must see an idle control word
    // for the whole cycle reset_n is low, whatever state is still held.
    if (!reset_n) begin
      pc_en      = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_src_a  = 1'b0;
      reg_dst    = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
      pc_src     = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = LEN_ALU_OP'(ALU_NOP);
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
// Latency: n/a.
// Backpressure: mem_ready driven per cycle from tables.
module tb_multicycle_controller;

  logic        clk;
  logic        reset_n;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_en, i_or_d, ir_write, mem_read, mem_write, alu_src_a;
  logic        reg_dst, reg_write, mem_to_reg, instr_done, illegal_op;
  logic [1:0]  pc_src, alu_src_b;
  logic [2:0]  alu_op;
  logic [3:0]  state;
  logic [31:0] instr_count;

  int n_cmp = 0;
  int n_err = 0;

  // {pc_en,i_or_d,ir_write,mem_read,mem_write,alu_src_a,reg_dst,reg_write,
  //  mem_to_reg,instr_done,illegal_op, pc_src, alu_src_b, alu_op}
  logic [17:0] ctrl;
  assign ctrl = {pc_en, i_or_d, ir_write, mem_read, mem_write, alu_src_a, reg_dst,
                 reg_write, mem_to_reg, instr_done, illegal_op, pc_src, alu_src_b, alu_op};

  // Hand-derived control words (ALU codes: NOP 0, ADD 1, SUB 2, AND 3, OR 4, RTYPE 5)
  localparam logic [17:0] C_IDLE     = 18'b0_0_0_0_0_0_0_0_0_0_0_00_00_000;
  localparam logic [17:0] C_FETCH_OK = 18'b1_0_1_1_0_0_0_0_0_0_0_00_01_001;
  localparam logic [17:0] C_FETCH_WT = 18'b0_0_0_1_0_0_0_0_0_0_0_00_01_001;
  localparam logic [17:0] C_DECODE   = 18'b0_0_0_0_0_0_0_0_0_0_0_00_11_001;
  localparam logic [17:0] C_ILLEGAL  = 18'b0_0_0_0_0_0_0_0_0_0_1_00_11_001;
  localparam logic [17:0] C_MEM_ADDR = 18'b0_0_0_0_0_1_0_0_0_0_0_00_10_001;
  localparam logic [17:0] C_MEM_RD   = 18'b0_1_0_1_0_0_0_0_0_0_0_00_00_000;
  localparam logic [17:0] C_MEM_WB   = 18'b0_0_0_0_0_0_0_1_1_1_0_00_00_000;
  localparam logic [17:0] C_MEM_WR_W = 18'b0_1_0_0_1_0_0_0_0_0_0_00_00_000;
  localparam logic [17:0] C_MEM_WR_D = 18'b0_1_0_0_1_0_0_0_0_1_0_00_00_000;
  localparam logic [17:0] C_EXEC_R   = 18'b0_0_0_0_0_1_0_0_0_0_0_00_00_101;
  localparam logic [17:0] C_R_WB     = 18'b0_0_0_0_0_0_1_1_0_1_0_00_00_000;
  localparam logic [17:0] C_EXEC_ADD = 18'b0_0_0_0_0_1_0_0_0_0_0_00_10_001;
  localparam logic [17:0] C_EXEC_OR  = 18'b0_0_0_0_0_1_0_0_0_0_0_00_10_100;
  localparam logic [17:0] C_I_WB     = 18'b0_0_0_0_0_0_0_1_0_1_0_00_00_000;
  localparam logic [17:0] C_BR_TAKEN = 18'b1_0_0_0_0_1_0_0_0_1_0_01_00_010;
  localparam logic [17:0] C_BR_NOT   = 18'b0_0_0_0_0_1_0_0_0_1_0_01_00_010;
  localparam logic [17:0] C_JUMP     = 18'b1_0_0_0_0_0_0_0_0_1_0_10_00_000;

  multicycle_controller #(.LEN_OP_CODE(6), .LEN_ALU_OP(3)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .i_or_d(i_or_d), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .alu_src_a(alu_src_a), .reg_dst(reg_dst),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .instr_done(instr_done),
    .illegal_op(illegal_op), .pc_src(pc_src), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .state(state), .instr_count(instr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Each cycle: drive at negedge, sample 1ns later, well away from posedge.
  task automatic test_reset();
    @(negedge clk); reset_n = 1'b0; mem_ready = 1'b1; opcode = 6'h00; zero = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (ctrl !== C_IDLE) begin n_err++; $display("FAIL reset_ctrl: got %b want %b", ctrl, C_IDLE); end
    n_cmp++; if (state !== 4'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if (instr_count !== 32'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", instr_count); end
    @(negedge clk); reset_n = 1'b1; mem_ready = 1'b0; #1;
    n_cmp++; if (ctrl !== C_FETCH_WT) begin n_err++; $display("FAIL post_reset_fetch: got %b want %b", ctrl, C_FETCH_WT); end
  endtask

  task automatic test_rtype();
    logic [3:0]  st [4];
    logic [17:0] cw [4];
    st = '{4'd0, 4'd1, 4'd6, 4'd7};
    cw = '{C_FETCH_OK, C_DECODE, C_EXEC_R, C_R_WB};
    opcode = 6'h00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_ready = 1'b1; #1;
      n_cmp++; if (state !== st[i]) begin n_err++; $display("FAIL rtype_state c%0d: got %0d want %0d", i, state, st[i]); end
      n_cmp++; if (ctrl !== cw[i]) begin n_err++; $display("FAIL rtype_ctrl c%0d: got %b want %b", i, ctrl, cw[i]); end
    end
    @(negedge clk); mem_ready = 1'b0; #1;
    n_cmp++; if (instr_count !== 32'd1) begin n_err++; $display("FAIL rtype_count: got %0d want 1", instr_count); end
  endtask

  task automatic test_lw_wait();
    logic [3:0]  st [7];
    logic [17:0] cw [7];
    logic        rd [7];
    st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
    cw = '{C_FETCH_OK, C_DECODE, C_MEM_ADDR, C_MEM_RD, C_MEM_RD, C_MEM_RD, C_MEM_WB};
    rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    opcode = 6'h23;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); mem_ready = rd[i]; #1;
      n_cmp++; if (state !== st[i]) begin n_err++; $display("FAIL lw_state c%0d: got %0d want %0d", i, state, st[i]); end
      n_cmp++; if (ctrl !== cw[i]) begin n_err++; $display("FAIL lw_ctrl c%0d: got %b want %b", i, ctrl, cw[i]); end
    end
    @(negedge clk); mem_ready = 1'b0; #1;
    n_cmp++; if (state !== 4'd0) begin n_err++; $display("FAIL lw_return: got %0d want 0", state); end
    n_cmp++; if (instr_count !== 32'd2) begin n_err++; $display("FAIL lw_count: got %0d want 2", instr_count); end
  endtask

  task automatic test_sw_wait();
    logic [3:0]  st [5];
    logic [17:0] cw [5];
    logic        rd [5];
    st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
    cw = '{C_FETCH_OK, C_DECODE, C_MEM_ADDR, C_MEM_WR_W, C_MEM_WR_D};
    rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    opcode = 6'h2B;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); mem_ready = rd[i]; #1;
      n_cmp++; if (state !== st[i]) begin n_err++; $display("FAIL sw_state c%0d: got %0d want %0d", i, state, st[i]); end
      n_cmp++; if (ctrl !== cw[i]) begin n_err++; $display("FAIL sw_ctrl c%0d: got %b want %b", i, ctrl, cw[i]); end
    end
    @(negedge clk); mem_ready = 1'b0; #1;
    n_cmp++; if (instr_count !== 32'd3) begin n_err++; $display("FAIL sw_count: got %0d want 3", instr_count); end
  endtask

  task automatic test_itype();
    logic [5:0]  ops [2];
    logic [17:0] ex  [2];
    ops = '{6'h08, 6'h0D};
    ex  = '{C_EXEC_ADD, C_EXEC_OR};
    for (int k = 0; k < 2; k++) begin
      logic [3:0]  st [4];
      logic [17:0] cw [4];
      st = '{4'd0, 4'd1, 4'd8, 4'd9};
      cw = '{C_FETCH_OK, C_DECODE, ex[k], C_I_WB};
      opcode = ops[k];
      for (int i = 0; i < 4; i++) begin
        @(negedge clk); mem_ready = 1'b1; #1;
        n_cmp++; if (state !== st[i]) begin n_err++; $display("FAIL itype%0d_state c%0d: got %0d want %0d", k, i, state, st[i]); end
        n_cmp++; if (ctrl !== cw[i]) begin n_err++; $display("FAIL itype%0d_ctrl c%0d: got %b want %b", k, i, ctrl, cw[i]); end
      end
    end
    @(negedge clk); mem_ready = 1'b0; #1;
    n_cmp++; if (instr_count !== 32'd5) begin n_err++; $display("FAIL itype_count: got %0d want 5", instr_count); end
  endtask

  task automatic test_branch();
    logic        zv [2];
    logic [17:0] bw [2];
    zv = '{1'b1, 1'b0};
    bw = '{C_BR_TAKEN, C_BR_NOT};
    opcode = 6'h04;
    for (int k = 0; k < 2; k++) begin
      logic [3:0]  st [3];
      logic [17:0] cw [3];
      st = '{4'd0, 4'd1, 4'd10};
      cw = '{C_FETCH_OK, C_DECODE, bw[k]};
      zero = zv[k];
      for (int i = 0; i < 3; i++) begin
        @(negedge clk); mem_ready = 1'b1; #1;
        n_cmp++; if (state !== st[i]) begin n_err++; $display("FAIL beq%0d_state c%0d: got %0d want %0d", k, i, state, st[i]); end
        n_cmp++; if (ctrl !== cw[i]) begin n_err++; $display("FAIL beq%0d_ctrl c%0d: got %b want %b", k, i, ctrl, cw[i]); end
      end
    end
    zero = 1'b0;
    @(negedge clk); mem_ready = 1'b0; #1;
    n_cmp++; if (instr_count !== 32'd7) begin n_err++; $display("FAIL beq_count: got %0d want 7", instr_count); end
  endtask

  task automatic test_illegal();
    opcode = 6'h3F;
    @(negedge clk); mem_ready = 1'b1; #1;
    n_cmp++; if (ctrl !== C_FETCH_OK) begin n_err++; $display("FAIL ill_fetch: got %b want %b", ctrl, C_FETCH_OK); end
    @(negedge clk); #1;
    n_cmp++; if (state !== 4'd1) begin n_err++; $display("FAIL ill_state: got %0d want 1", state); end
    n_cmp++; if (ctrl !== C_ILLEGAL) begin n_err++; $display("FAIL ill_ctrl: got %b want %b", ctrl, C_ILLEGAL); end
    @(negedge clk); mem_ready = 1'b0; #1;
    n_cmp++; if (state !== 4'd0) begin n_err++; $display("FAIL ill_return: got %0d want 0", state); end
    n_cmp++; if (instr_count !== 32'd7) begin n_err++; $display("FAIL ill_count: got %0d want 7", instr_count); end
  endtask

  task automatic test_jump(input logic [31:0] exp_count, input string tag);
    logic [3:0]  st [3];
    logic [17:0] cw [3];
    st = '{4'd0, 4'd1, 4'd11};
    cw = '{C_FETCH_OK, C_DECODE, C_JUMP};
    opcode = 6'h02;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_ready = 1'b1; #1;
      n_cmp++; if (state !== st[i]) begin n_err++; $display("FAIL %s_state c%0d: got %0d want %0d", tag, i, state, st[i]); end
      n_cmp++; if (ctrl !== cw[i]) begin n_err++; $display("FAIL %s_ctrl c%0d: got %b want %b", tag, i, ctrl, cw[i]); end
    end
    @(negedge clk); mem_ready = 1'b0; #1;
    n_cmp++; if (instr_count !== exp_count) begin n_err++; $display("FAIL %s_count: got %0h want %0h", tag, instr_count, exp_count); end
  endtask

  task automatic test_reset_mid_wait();
    opcode = 6'h2B;
    @(negedge clk); mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); mem_ready = 1'b0; #1;
    n_cmp++; if (state !== 4'd5) begin n_err++; $display("FAIL rst_wait_state: got %0d want 5", state); end
    @(negedge clk); reset_n = 1'b0; #1;
    n_cmp++; if (ctrl !== C_IDLE) begin n_err++; $display("FAIL rst_wait_ctrl: got %b want %b", ctrl, C_IDLE); end
    @(negedge clk); reset_n = 1'b1; #1;
    n_cmp++; if (state !== 4'd0) begin n_err++; $display("FAIL rst_wait_fetch: got %0d want 0", state); end
    n_cmp++; if (instr_count !== 32'd0) begin n_err++; $display("FAIL rst_wait_count: got %0d want 0", instr_count); end
    n_cmp++; if (ctrl !== C_FETCH_WT) begin n_err++; $display("FAIL rst_wait_fetch_ctrl: got %b want %b", ctrl, C_FETCH_WT); end
  endtask

  task automatic test_wrap();
    @(negedge clk); mem_ready = 1'b0;
    force dut.instr_count = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.instr_count;
    #1;
    n_cmp++; if (instr_count !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_preload: got %0h want ffffffff", instr_count); end
    test_jump(32'd0, "wrap");
  endtask

  initial begin
    reset_n = 1'b0; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw_wait();
    test_itype();
    test_branch();
    test_illegal();
    test_jump(32'd8, "jump");
    test_reset_mid_wait();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
